// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between a fetch port and a data port, with data priority, a fetch starvation bound and fetch flush
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic kill_q, kill_d, srv_d_q, srv_d_d, m_req_q, m_req_d, m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic d_grant, i_grant, done;
  always_comb begin
    d_grant = state_q == IDLE && d_req && !(i_req && streak_q == SW'(MAX_D_STREAK));
    i_grant = state_q == IDLE && !d_grant && i_req && !i_flush;
    done = (state_q == BUSY_I || state_q == BUSY_D) && m_req_q && m_ready;
    state_d = d_grant ? BUSY_D : i_grant ? BUSY_I : done ? RESP : state_q == RESP ? IDLE : state_q;
    srv_d_d = d_grant | (!i_grant & srv_d_q);
    streak_d = d_grant ? (i_req ? streak_q + SW'(1) : '0) : i_grant ? '0 : streak_q;
    kill_d = state_d == IDLE ? 1'b0
           : kill_q | (i_flush && (state_q == BUSY_I || (state_q == RESP && !srv_d_q)));
    m_req_d = (d_grant | i_grant) ? 1'b1 : done ? 1'b0 : m_req_q;
    m_we_d = d_grant ? d_we : (i_grant | done) ? 1'b0 : m_we_q;
    m_addr_d = d_grant ? d_addr : i_grant ? i_addr : m_addr_q;
    m_wdata_d = d_grant ? d_wdata : m_wdata_q;
    i_rdata_d = (done && state_q == BUSY_I && !kill_q && !i_flush) ? m_rdata : i_rdata_q;
    d_rdata_d = (done && state_q == BUSY_D && !m_we_q) ? m_rdata : d_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      kill_q    <= 1'b0;
      srv_d_q   <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      kill_q    <= kill_d;
      srv_d_q   <= srv_d_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign i_ack = state_q == RESP && !srv_d_q && !kill_q && !i_flush;
  assign d_ack = state_q == RESP && srv_d_q;
  assign m_req = m_req_q;
  assign m_we = m_we_q;
  assign m_addr = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 0, reset = 0;
  logic i_req = 0, i_flush = 0, d_req = 0, d_we = 0, m_ready = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic i_ack, d_ack, m_req, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  int tests = 0, fails = 0;
  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_m_req", {31'd0, m_req}, 0);
    chk("rst_m_we", {31'd0, m_we}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_i_ack", {31'd0, i_ack}, 0);
    chk("rst_d_ack", {31'd0, d_ack}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    reset = 1; i_req = 1; i_addr = 32'h40; m_ready = 1; m_rdata = 32'h8C020004;
    tick();
    chk("f1_m_req", {31'd0, m_req}, 1);
    chk("f1_m_addr", m_addr, 32'h40);
    chk("f1_m_we", {31'd0, m_we}, 0);
    chk("f1_i_ack_early", {31'd0, i_ack}, 0);
    tick();
    chk("f1_i_ack", {31'd0, i_ack}, 1);
    chk("f1_i_rdata", i_rdata, 32'h8C020004);
    chk("f1_m_req_drop", {31'd0, m_req}, 0);
    i_req = 0;
    tick();
    chk("f1_i_ack_pulse", {31'd0, i_ack}, 0);
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; m_ready = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("w_m_req", {31'd0, m_req}, 1);
      chk("w_m_we", {31'd0, m_we}, 1);
      chk("w_m_addr", m_addr, 32'h100);
      chk("w_m_wdata", m_wdata, 32'hDEADBEEF);
      chk("w_d_ack_early", {31'd0, d_ack}, 0);
      if (k == 3) m_ready = 1;
    end
    tick();
    chk("w_d_ack", {31'd0, d_ack}, 1);
    chk("w_m_req_drop", {31'd0, m_req}, 0);
    chk("w_m_we_drop", {31'd0, m_we}, 0);
    chk("w_d_rdata", d_rdata, 0);
    d_req = 0; d_we = 0;
    tick();
    chk("w_d_ack_pulse", {31'd0, d_ack}, 0);
    chk("w_addr_hold", m_addr, 32'h100);
    d_req = 1; i_req = 1; d_addr = 32'h200; i_addr = 32'h44; m_rdata = 32'h11112222;
    tick();
    chk("s_grant_d", m_addr, 32'h200);
    tick();
    chk("s_d_ack", {31'd0, d_ack}, 1);
    chk("s_i_ack_low", {31'd0, i_ack}, 0);
    chk("s_d_rdata", d_rdata, 32'h11112222);
    d_req = 0; m_rdata = 32'h33334444;
    tick();
    chk("s_idle_d_ack", {31'd0, d_ack}, 0);
    tick();
    chk("s_grant_i", m_addr, 32'h44);
    chk("s_grant_i_we", {31'd0, m_we}, 0);
    tick();
    chk("s_i_ack", {31'd0, i_ack}, 1);
    chk("s_d_ack_low", {31'd0, d_ack}, 0);
    chk("s_i_rdata", i_rdata, 32'h33334444);
    i_req = 0;
    tick();
    d_req = 1; i_req = 1; d_addr = 32'h300; i_addr = 32'h48;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k % 5 == 4) begin
        chk("st_grant_i", m_addr, 32'h48);
        chk("st_streak_clr", {29'd0, dut.streak_q}, 0);
      end else begin
        chk("st_grant_d", m_addr, 32'h300);
        chk("st_streak", {29'd0, dut.streak_q}, 32'(k % 5 + 1));
      end
      tick();
      chk("st_one_ack", {31'd0, i_ack & d_ack}, 0);
      tick();
    end
    d_req = 0; i_req = 0;
    i_req = 1; i_addr = 32'h50; m_ready = 0; m_rdata = 32'h55556666;
    tick();
    chk("fl_grant", m_addr, 32'h50);
    i_flush = 1; i_req = 0;
    tick();
    i_flush = 0;
    tick();
    chk("fl_still_busy", {31'd0, m_req}, 1);
    m_ready = 1;
    tick();
    chk("fl_no_ack", {31'd0, i_ack}, 0);
    chk("fl_rdata_hold", i_rdata, 32'h33334444);
    chk("fl_m_req_drop", {31'd0, m_req}, 0);
    tick();
    i_req = 1; i_addr = 32'h60; m_rdata = 32'h77778888;
    tick();
    chk("fl_regrant", m_addr, 32'h60);
    tick();
    chk("fl_regrant_ack", {31'd0, i_ack}, 1);
    chk("fl_regrant_rdata", i_rdata, 32'h77778888);
    i_req = 0;
    tick();
    i_req = 1; i_flush = 1; i_addr = 32'h64;
    tick();
    chk("fi_blocked", {31'd0, m_req}, 0);
    i_flush = 0;
    tick();
    chk("fi_grant", m_addr, 32'h64);
    chk("fi_grant_req", {31'd0, m_req}, 1);
    tick();
    chk("fi_ack", {31'd0, i_ack}, 1);
    i_req = 0;
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h12345678; m_ready = 0;
    tick();
    chk("rm_busy", {31'd0, m_req}, 1);
    reset = 0;
    tick();
    chk("rm_m_req", {31'd0, m_req}, 0);
    chk("rm_m_we", {31'd0, m_we}, 0);
    chk("rm_m_addr", m_addr, 0);
    chk("rm_m_wdata", m_wdata, 0);
    chk("rm_d_ack", {31'd0, d_ack}, 0);
    chk("rm_i_rdata", i_rdata, 0);
    chk("rm_d_rdata", d_rdata, 0);
    reset = 1;
    tick();
    chk("rm_regrant", {31'd0, m_req}, 1);
    chk("rm_regrant_addr", m_addr, 32'h400);
    m_ready = 1;
    tick();
    chk("rm_d_ack_after", {31'd0, d_ack}, 1);
    d_req = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
